// File: rtl/vm_panel_arbiter.sv
// Two-panel arbiter sharing one vending core: round-robin grant, drain on beverage, registered routing.
// Optional idle-timeout revocation enabled by defining VM_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module vm_panel_arbiter #(
  parameter int unsigned IDLE_TIMEOUT = 16,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] coin_a,
  input  logic [2:0] coin_b,
  input  logic [1:0] button_a,
  input  logic [1:0] button_b,
  output logic [2:0] coin_out,
  output logic [1:0] button_out,
  input  logic [1:0] change_in,
  input  logic [1:0] beverage_in,
  output logic [1:0] change_a,
  output logic [1:0] change_b,
  output logic [1:0] beverage_a,
  output logic [1:0] beverage_b,
  output logic       grant_a,
  output logic       grant_b,
  output logic       rej_a,
  output logic       rej_b
);

  localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);
  localparam int unsigned TW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, GNT_A, GNT_B, DRN_A, DRN_B} state_e;

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;          // 1: panel B wins a tie
  logic [DW-1:0] drn_cnt_q, drn_cnt_d;
  logic [2:0]    coin_out_q, coin_out_d;
  logic [1:0]    button_out_q, button_out_d;
  logic [1:0]    change_a_q, change_a_d, change_b_q, change_b_d;
  logic [1:0]    bev_a_q, bev_a_d, bev_b_q, bev_b_d;
  logic          grant_a_q, grant_a_d, grant_b_q, grant_b_d;
  logic          rej_a_q, rej_a_d, rej_b_q, rej_b_d;

  logic [2:0] coin_a_v, coin_b_v;
  logic [1:0] btn_a_v, btn_b_v;
  logic       req_a, req_b;

  // Out-of-range codes collapse to "none"
  assign coin_a_v = (coin_a > 3'd5) ? 3'd0 : coin_a;
  assign coin_b_v = (coin_b > 3'd5) ? 3'd0 : coin_b;
  assign btn_a_v  = (button_a == 2'd3) ? 2'd0 : button_a;
  assign btn_b_v  = (button_b == 2'd3) ? 2'd0 : button_b;
  assign req_a    = (coin_a_v != 3'd0);
  assign req_b    = (coin_b_v != 3'd0);

`ifdef VM_ARB_TIMEOUT_EN
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout_c;

  // Counts idle cycles of the granted panel; any activity or leaving GNT clears it
  always_comb begin
    to_cnt_d  = '0;
    timeout_c = 1'b0;
    if ((state_q == GNT_A && coin_a_v == 3'd0 && btn_a_v == 2'd0) ||
        (state_q == GNT_B && coin_b_v == 3'd0 && btn_b_v == 2'd0)) begin
      if (TW'(to_cnt_q + TW'(1)) == TW'(IDLE_TIMEOUT)) begin
        timeout_c = 1'b1;
      end else begin
        to_cnt_d = TW'(to_cnt_q + TW'(1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) to_cnt_q <= '0;
    else      to_cnt_q <= to_cnt_d;
  end
`else
  // Timeout disabled: the parameter stays on the interface but drives nothing
  logic [TW-1:0] to_unused;
  logic          timeout_c;
  assign to_unused = '0;
  assign timeout_c = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    drn_cnt_d    = '0;
    coin_out_d   = 3'd0;
    button_out_d = 2'd0;
    change_a_d   = 2'd0;
    change_b_d   = 2'd0;
    bev_a_d      = 2'd0;
    bev_b_d      = 2'd0;
    rej_a_d      = 1'b0;
    rej_b_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_a && (!req_b || !ptr_q)) begin
          state_d    = GNT_A;
          coin_out_d = coin_a_v;
          rej_b_d    = req_b;
        end else if (req_b) begin
          state_d    = GNT_B;
          coin_out_d = coin_b_v;
          rej_a_d    = req_a;
        end
      end
      GNT_A: begin
        coin_out_d   = coin_a_v;
        button_out_d = btn_a_v;
        change_a_d   = change_in;
        bev_a_d      = beverage_in;
        rej_b_d      = req_b;
        if (beverage_in != 2'd0 || timeout_c) state_d = DRN_A;
      end
      GNT_B: begin
        coin_out_d   = coin_b_v;
        button_out_d = btn_b_v;
        change_b_d   = change_in;
        bev_b_d      = beverage_in;
        rej_a_d      = req_a;
        if (beverage_in != 2'd0 || timeout_c) state_d = DRN_B;
      end
      DRN_A, DRN_B: begin
        rej_a_d = req_a;
        rej_b_d = req_b;
        if (state_q == DRN_A) begin
          change_a_d = change_in;
          bev_a_d    = beverage_in;
        end else begin
          change_b_d = change_in;
          bev_b_d    = beverage_in;
        end
        // A nonzero change restarts the quiet-cycle count
        if (change_in == 2'd0) begin
          if (DW'(drn_cnt_q + DW'(1)) == DW'(DRAIN_CYCLES)) begin
            state_d = IDLE;
            ptr_d   = (state_q == DRN_A);
          end else begin
            drn_cnt_d = DW'(drn_cnt_q + DW'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
    grant_a_d = (state_d == GNT_A) || (state_d == DRN_A);
    grant_b_d = (state_d == GNT_B) || (state_d == DRN_B);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      drn_cnt_q    <= '0;
      coin_out_q   <= 3'd0;
      button_out_q <= 2'd0;
      change_a_q   <= 2'd0;
      change_b_q   <= 2'd0;
      bev_a_q      <= 2'd0;
      bev_b_q      <= 2'd0;
      grant_a_q    <= 1'b0;
      grant_b_q    <= 1'b0;
      rej_a_q      <= 1'b0;
      rej_b_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      drn_cnt_q    <= drn_cnt_d;
      coin_out_q   <= coin_out_d;
      button_out_q <= button_out_d;
      change_a_q   <= change_a_d;
      change_b_q   <= change_b_d;
      bev_a_q      <= bev_a_d;
      bev_b_q      <= bev_b_d;
      grant_a_q    <= grant_a_d;
      grant_b_q    <= grant_b_d;
      rej_a_q      <= rej_a_d;
      rej_b_q      <= rej_b_d;
    end
  end

  assign coin_out   = coin_out_q;
  assign button_out = button_out_q;
  assign change_a   = change_a_q;
  assign change_b   = change_b_q;
  assign beverage_a = bev_a_q;
  assign beverage_b = bev_b_q;
  assign grant_a    = grant_a_q;
  assign grant_b    = grant_b_q;
  assign rej_a      = rej_a_q;
  assign rej_b      = rej_b_q;

endmodule

// File: doc/vm_panel_arbiter.md
VM_PANEL_ARBITER -- requirements
Module: vm_panel_arbiter

Interface
REQ-001 Parameter IDLE_TIMEOUT, default 16, sets the number of cycles of panel inactivity before the grant is revoked.
REQ-002 Parameter DRAIN_CYCLES, default 2, sets the number of consecutive change_in==0 cycles that end a drain.
REQ-003 Port clk, input, 1 bit: single clock; all logic is on the rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Ports coin_a/coin_b, input, 3 bits: panel coin (0 none, 1 10c, 2 20c, 3 50c, 4 1E, 5 2E); 6 and 7 are treated as 0.
REQ-006 Ports button_a/button_b, input, 2 bits: panel selection (0 none, 1 water, 2 soda); 3 is treated as 0.
REQ-007 Port coin_out, output, 3 bits: coin forwarded to the shared vending core.
REQ-008 Port button_out, output, 2 bits: selection forwarded to the core.
REQ-009 Port change_in, input, 2 bits: core change (0 none, 1 10c, 2 20c).
REQ-010 Port beverage_in, input, 2 bits: core beverage (0 none, 1 water, 2 soda).
REQ-011 Ports change_a/change_b and beverage_a/beverage_b, output, 2 bits each: core results routed to the panel.
REQ-012 Ports grant_a/grant_b, output, 1 bit each: the panel owns the core; the two are never both 1.
REQ-013 Ports rej_a/rej_b, output, 1 bit each: one-cycle pulse when a nonzero coin from that panel is dropped.

Function
REQ-014 States: IDLE, GNT_A, GNT_B, DRN_A, DRN_B.
REQ-015 Request: a valid nonzero coin on a panel; buttons alone never request.
REQ-016 IDLE, single request: go to GNT_x of the requester; its coin appears on coin_out the next cycle.
REQ-017 IDLE, both request: round-robin; the winner is the panel not served last; after reset the pointer favours A; the loser's rej_x pulses the next cycle.
REQ-018 GNT_x: coin_out/button_out are the registered (1-cycle) copy of panel x inputs.
REQ-019 GNT_x: change_x/beverage_x are the registered copy of change_in/beverage_in; the other panel's outputs are 0.
REQ-020 GNT_x, any nonzero coin from the other panel: the coin is dropped and rej pulses 1 cycle later.
REQ-021 GNT_x, beverage_in!=0: go to DRN_x.
REQ-022 DRN_x: coin_out=0 and button_out=0; change_in/beverage_in continue to route to panel x; coins from either panel are rejected.
REQ-023 DRN_x exit: after DRAIN_CYCLES consecutive cycles with change_in==0, go to IDLE; set the pointer to x (x becomes low priority); a nonzero change_in restarts the count.
REQ-024 grant_x=1 in GNT_x and DRN_x, 0 elsewhere; the grant is registered together with the state.
REQ-025 A request in the same cycle as a DRN to IDLE transition is not seen; it is arbitrated from the next cycle in IDLE.
REQ-026 No panel-to-core or core-to-panel path is combinational; latency is exactly 1 cycle each way.

Reset
REQ-027 While rst==0: state=IDLE, pointer=A, counters=0, and all outputs are 0 immediately, independent of clk.
REQ-028 Reset mid-transaction discards the grant without draining; core credit recovery is out of scope.
REQ-029 First active edge after rst rises: normal arbitration.

Configuration
REQ-030 Macro VM_ARB_TIMEOUT_EN defined: in GNT_x, a counter increments each cycle in which panel x has coin==0 and button==0; it clears on any activity.
REQ-031 VM_ARB_TIMEOUT_EN defined: when the counter reaches IDLE_TIMEOUT, go to DRN_x; if beverage_in!=0 in the same cycle, the beverage path is taken (identical target, counter cleared).
REQ-032 VM_ARB_TIMEOUT_EN undefined: no counter exists and the grant is held until beverage_in!=0.

Verification
REQ-033 A: coin_a=4 for 1 cycle, B idle -> grant_a=1 next cycle, coin_out=4 one cycle after coin_a, rej_b=0.
REQ-034 After reset, coin_a=3 and coin_b=3 on the same cycle -> grant_a, rej_b pulse; after A completes, repeat the same stimulus -> grant_b, rej_a.
REQ-035 In GNT_A, beverage_in=2 then change_in=1,1,0,0 -> beverage_a=2, change_a=1,1 each 1 cycle later, change_b=0 throughout, IDLE after 2 zero cycles.
REQ-036 In GNT_B, coin_a=5 -> rej_a pulse, coin_out stays 0 for that coin.
REQ-037 VM_ARB_TIMEOUT_EN, IDLE_TIMEOUT=16: grant_a, then 16 idle cycles -> DRN_A, grant_a drops DRAIN_CYCLES later; without the macro -> grant_a stays high.
REQ-038 rst=0 asserted in DRN_B with change_in=2 -> all outputs 0 immediately, IDLE after release.
